lua_mem_arbiter: RTL and testbench

//   Shares the single Avalon-MM master of lua_cpu between its internal memory

---
 rtl/lua_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_lua_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lua_mem_arbiter.sv
// lua_mem_arbiter: round-robin sharing of the lua_cpu Avalon-MM master between
// the program counter, instruction register and register-file spill/fill.
// A grant is registered in IDLE and held in GRANT until the granted transfer
// completes (waitrequest low) or the requester withdraws its strobe.
//
// Handshake: each requester holds read/write (and address/data) until it sees
// its req_waitrequest bit low in a cycle; that cycle is the accept cycle and
// req_readdata is valid for reads. The master side follows Avalon-MM: strobes
// stay stable while mem_waitrequest is high.
module lua_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_address,
  input  logic [NUM_REQ*DATA_W-1:0]    req_writedata,
  input  logic [NUM_REQ-1:0]           req_read,
  input  logic [NUM_REQ-1:0]           req_write,
  output logic [DATA_W-1:0]            req_readdata,
  output logic [NUM_REQ-1:0]           req_waitrequest,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_writedata,
  output logic                         mem_read,
  output logic                         mem_write,
  input  logic [DATA_W-1:0]            mem_readdata,
  input  logic                         mem_waitrequest,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
  output logic                         busy,
  output logic                         proto_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic               proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0] pending;
  logic [IDX_W-1:0]   winner;
  logic               any_pending;

  logic [ADDR_W-1:0]  sel_address;
  logic [DATA_W-1:0]  sel_writedata;
  logic               sel_read;
  logic               sel_write;

  assign pending = req_read | req_write;

  // Round-robin pick: first pending index above last_idx, else wrap to the lowest.
  always_comb begin
    winner      = last_idx_q;
    any_pending = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_pending && pending[i] && (IDX_W'(i) > last_idx_q)) begin
        winner      = IDX_W'(i);
        any_pending = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_pending && pending[i] && (IDX_W'(i) <= last_idx_q)) begin
        winner      = IDX_W'(i);
        any_pending = 1'b1;
      end
    end
  end

  // Select the bus of the registered grant (mux keyed on constant indices).
  always_comb begin
    sel_address   = '0;
    sel_writedata = '0;
    sel_read      = 1'b0;
    sel_write     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_address   = req_address[i*ADDR_W +: ADDR_W];
        sel_writedata = req_writedata[i*DATA_W +: DATA_W];
        sel_read      = req_read[i];
        sel_write     = req_write[i];
      end
    end
  end

  // Next-state logic and master/requester outputs; IDLE drives an all-quiet bus.
  always_comb begin
    state_d         = state_q;
    grant_idx_d     = grant_idx_q;
    last_idx_d      = last_idx_q;
    proto_err_d     = proto_err_q;
    mem_address     = '0;
    mem_writedata   = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    req_waitrequest = '1;

    unique case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          grant_idx_d = winner;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        mem_address   = sel_address;
        mem_writedata = sel_writedata;
        mem_read      = sel_read;
        // Read wins a read+write collision; the collision is flagged below.
        mem_write     = sel_write & ~sel_read;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_idx_q == IDX_W'(i)) begin
            req_waitrequest[i] = mem_waitrequest;
          end
        end
        if (sel_read && sel_write) begin
          proto_err_d = 1'b1;
        end
        // Completion or withdrawn request both release the grant.
        if (!(sel_read || sel_write) || !mem_waitrequest) begin
          last_idx_d = grant_idx_q;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign req_readdata = mem_readdata;
  assign grant_idx    = grant_idx_q;
  assign busy         = (state_q == ST_GRANT);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_lua_mem_arbiter.sv
// Directed bench for lua_mem_arbiter with three requesters.
module tb_lua_mem_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_writedata;
  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_W-1:0]         mem_readdata;
  logic                      mem_waitrequest;
  logic [1:0]                grant_idx;
  logic                      busy;
  logic                      proto_err;

  int errors = 0;
  int checks = 0;

  lua_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_address     (req_address),
    .req_writedata   (req_writedata),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_readdata    (req_readdata),
    .req_waitrequest (req_waitrequest),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .grant_idx       (grant_idx),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus idle: all master outputs zero and all requesters stalled.
  task automatic check_quiet(input string tag);
    check({tag, "_rd"},   mem_read, 1'b0);
    check({tag, "_wr"},   mem_write, 1'b0);
    check({tag, "_addr"}, mem_address, 32'h0);
    check({tag, "_wdat"}, mem_writedata, 32'h0);
    check({tag, "_wreq"}, req_waitrequest, 3'b111);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Poll (bounded) on falling edges for a grant that is accepted this cycle.
  task automatic wait_accept(output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = 2'd0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (busy && req_waitrequest[grant_idx] == 1'b0) begin
        ok = 1'b1;
        g  = grant_idx;
      end
    end
  endtask

  logic [1:0] g;
  bit         ok;
  logic [1:0] exp_order [3] = '{2'd0, 2'd1, 2'd2};

  initial begin
    rst             = 1'b1;
    req_address     = '0;
    req_writedata   = '0;
    req_read        = '0;
    req_write       = '0;
    mem_readdata    = '0;
    mem_waitrequest = 1'b0;

    // 1. Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    check("rst_gidx", grant_idx, 2'd0);
    check("rst_perr", proto_err, 1'b0);

    // 2. Single read from requester 1, zero wait
    @(posedge clk); #1;
    rst                  = 1'b0;
    req_read[1]          = 1'b1;
    req_address[32 +: 32] = 32'h100;
    mem_readdata         = 32'hDEADBEEF;
    mem_waitrequest      = 1'b0;
    @(negedge clk);
    check("t2_idle_rd", mem_read, 1'b0);
    check("t2_idle_wreq", req_waitrequest, 3'b111);
    @(negedge clk);
    check("t2_rd", mem_read, 1'b1);
    check("t2_wr", mem_write, 1'b0);
    check("t2_addr", mem_address, 32'h100);
    check("t2_wreq", req_waitrequest, 3'b101);
    check("t2_rdata", req_readdata, 32'hDEADBEEF);
    check("t2_gidx", grant_idx, 2'd1);
    check("t2_busy", busy, 1'b1);
    @(posedge clk); #1;
    req_read[1] = 1'b0;
    @(negedge clk);
    check_quiet("t2_done");

    // 3. All three pending from reset: order 0,1,2, then 0 alone
    @(posedge clk); #1;
    rst         = 1'b1;
    req_read    = 3'b111;
    req_address = {32'hA2, 32'hA1, 32'hA0};
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_accept(g, ok);
      check("t3_accept", ok, 1'b1);
      check("t3_order", g, exp_order[k]);
      check("t3_addr", mem_address, 32'hA0 + 32'(exp_order[k]));
      @(posedge clk); #1;
      req_read[g] = 1'b0;
    end
    req_read[0] = 1'b1;
    wait_accept(g, ok);
    check("t3_again_accept", ok, 1'b1);
    check("t3_again_idx", g, 2'd0);
    @(posedge clk); #1;
    req_read[0] = 1'b0;

    // 4. Stalled write from 0 while 2 waits
    @(posedge clk); #1;
    req_write[0]          = 1'b1;
    req_address[0 +: 32]  = 32'h14;
    req_writedata[0 +: 32] = 32'h55;
    mem_waitrequest       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req_read[2]           = 1'b1;
        req_address[64 +: 32] = 32'h200;
      end
      if (i == 3) mem_waitrequest = 1'b0;
      @(negedge clk);
      check("t4_wr", mem_write, 1'b1);
      check("t4_addr", mem_address, 32'h14);
      check("t4_wdat", mem_writedata, 32'h55);
      check("t4_gidx", grant_idx, 2'd0);
      check("t4_wreq", req_waitrequest, (i < 3) ? 3'b111 : 3'b110);
    end
    @(posedge clk); #1;
    req_write[0] = 1'b0;
    @(negedge clk);
    check("t4_bubble_busy", busy, 1'b0);
    @(negedge clk);
    check("t4_g2_idx", grant_idx, 2'd2);
    check("t4_g2_rd", mem_read, 1'b1);
    check("t4_g2_addr", mem_address, 32'h200);
    check("t4_g2_wreq", req_waitrequest, 3'b011);
    @(posedge clk); #1;
    req_read[2] = 1'b0;

    // 5. Read+write collision on requester 2
    @(posedge clk); #1;
    req_read[2]           = 1'b1;
    req_write[2]          = 1'b1;
    req_address[64 +: 32] = 32'h300;
    @(negedge clk);
    check("t5_perr_pre", proto_err, 1'b0);
    @(negedge clk);
    check("t5_gidx", grant_idx, 2'd2);
    check("t5_rd", mem_read, 1'b1);
    check("t5_wr", mem_write, 1'b0);
    @(posedge clk); #1;
    req_read[2]  = 1'b0;
    req_write[2] = 1'b0;
    @(negedge clk);
    check("t5_perr", proto_err, 1'b1);
    check("t5_busy", busy, 1'b0);
    @(negedge clk);
    check("t5_perr_hold", proto_err, 1'b1);

    // 6. Reset while a grant is stalled
    @(posedge clk); #1;
    req_read[1]           = 1'b1;
    req_address[32 +: 32] = 32'h180;
    mem_waitrequest       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy", busy, 1'b1);
    check("t6_gidx", grant_idx, 2'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    req_read[1] = 1'b0;
    @(negedge clk);
    check_quiet("t6_rst");
    check("t6_gidx_rst", grant_idx, 2'd0);
    check("t6_perr_rst", proto_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
